seq_detect_mealy_p: RTL
=======================

SEQ_DETECT_MEALY_P -- requirements
Module: seq_detect_mealy_p

Interface
REQ-001 Parameter N, default 4, meaning pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011, N bits wide, meaning target sequence with PATTERN[N-1] received first.
REQ-003 Parameter OVERLAP, default 1, meaning 1 allows overlapping matches and 0 restarts after each match.
REQ-004 Parameter CNT_W, default 8, meaning match counter width, legal range 1..32.
REQ-005 clk  input  1  meaning single clock; all state updates on rising edge.
REQ-006 rst  input  1  meaning synchronous, active-high reset sampled on rising clk.
REQ-007 x  input  1  meaning serial data bit.
REQ-008 x_valid  input  1  meaning x is consumed this cycle; when low, state holds.
REQ-009 clr_cnt  input  1  meaning synchronous clear of match_cnt only.
REQ-010 y  output  1  meaning Mealy match flag, combinational from current state, x and x_valid.
REQ-011 y_q  output  1  meaning y registered, one cycle later.
REQ-012 match_cnt  output  CNT_W  meaning saturating count of matches.
REQ-013 state  output  clog2(N)  meaning current FSM state, for debug.

Function
REQ-014 FSM states S0..S(N-1) shall encode the length of the longest suffix of consumed bits that equals a proper prefix of PATTERN.
REQ-015 With x_valid=0, state, y_q input path and match_cnt shall hold; y shall be 0.
REQ-016 Match condition: x_valid=1, state=S(N-1), x=PATTERN[0].
REQ-017 y shall equal the match condition in the same cycle (zero latency, no register).
REQ-018 On a valid bit equal to the expected next pattern bit (PATTERN[N-1-state]) without completing the pattern, next state = state+1.
REQ-019 On a valid mismatching bit, next state = length of longest suffix of (matched prefix, x) that is a prefix of PATTERN (KMP failure transition), possibly S0.
REQ-020 On match with OVERLAP=1, next state = length of longest proper suffix of PATTERN that is also its prefix.
REQ-021 On match with OVERLAP=0, next state = S0.
REQ-022 Transition function shall be derived from PATTERN at elaboration; no runtime pattern load.
REQ-023 y_q shall register y every cycle, including cycles with x_valid=0.
REQ-024 match_cnt shall increment by 1 on each match; at 2^CNT_W-1 it shall hold (saturate, no wrap).
REQ-025 clr_cnt=1 shall set match_cnt to 0 next cycle; clr_cnt with simultaneous match -> 0 (clear wins).
REQ-026 clr_cnt shall not affect state, y or y_q.
REQ-027 No latch or X shall appear on any output for any input combination after reset.

Reset
REQ-028 rst=1 at rising clk shall set state=S0, y_q=0, match_cnt=0.
REQ-029 During rst=1, y shall be forced 0 and input bits shall be discarded.
REQ-030 rst has priority over x_valid and clr_cnt; reset mid-pattern discards partial progress.
REQ-031 Before the first reset, outputs are undefined; the bench shall reset at least one cycle first.

Verification
REQ-032 Defaults, OVERLAP=1, stream 1,0,1,1,0,1,1 all valid -> y=1 on bits 4 and 7 only; y_q=1 one cycle after each; match_cnt=2.
REQ-033 OVERLAP=0, same stream -> y=1 on bit 4 only; match_cnt=1; state=S0 after bit 4.
REQ-034 Stream 1,0,1,0,1,1 -> state after bit 4 = S2 (failure transition); y=1 on bit 6.
REQ-035 Stream 1,0,1,1 with x_valid=0 for 3 cycles between bits 2 and 3 -> state holds S2 in gaps, y=0 in gaps, y=1 on bit 4.
REQ-036 CNT_W=2, five matches -> match_cnt=3 after third match and holds; clr_cnt on a match cycle -> match_cnt=0.
REQ-037 rst asserted after 1,0,1 (state S3), then 1 -> no match, state=S1 after 1; y_q=0, match_cnt=0.

Source files
------------

// File: rtl/seq_detect_mealy_p.sv
// -----------------------------------------------------------------------------
// seq_detect_mealy_p
// Serial pattern detector built as a Mealy FSM. The state is the length of the
// longest suffix of the consumed bits that is also a proper prefix of PATTERN.
// The PATTERN MSB is the first bit received. The full transition table, which
// includes the KMP-style failure transitions, is computed from PATTERN at
// elaboration time.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset
//   x          in   1          serial data bit
//   x_valid    in   1          x is consumed this cycle; state holds when low
//   clr_cnt    in   1          synchronous clear of match_cnt only
//   y          out  1          combinational match flag (same cycle as last bit)
//   y_q        out  1          y delayed by one clock
//   match_cnt  out  CNT_W      saturating count of matches
//   state      out  clog2(N)   current FSM state (debug)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_detect_mealy_p #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x,
  input  logic                 x_valid,
  input  logic                 clr_cnt,
  output logic                 y,
  output logic                 y_q,
  output logic [CNT_W-1:0]     match_cnt,
  output logic [$clog2(N)-1:0] state
);

  localparam int SW = $clog2(N);
  // The table covers every code the state register can hold, so the lookup
  // never goes out of range. Codes >= N are unreachable and map to S0.
  localparam int NS = 1 << SW;

  typedef logic [SW-1:0] state_t;

  localparam state_t     LAST    = SW'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Next state after consuming bit b in state s. The result is the longest
  // proper prefix of PATTERN (length < N) that is a suffix of
  // (first s pattern bits, b). When the pattern completes, this gives the
  // border length, which is the correct overlap restart point.
  function automatic int kmp_next(input int s, input logic b);
    logic [N-1:0] seq;
    int           len;
    int           best;
    logic         ok;
    seq = '0;
    for (int i = 0; i < N; i++) begin
      if (i < s) seq[i] = PATTERN[N-1-i];
    end
    seq[s] = b;
    len  = s + 1;
    best = 0;
    for (int k = 1; k < N; k++) begin
      if (k <= len) begin
        ok = 1'b1;
        for (int j = 0; j < N; j++) begin
          if (j < k) begin
            if (seq[len-k+j] != PATTERN[N-1-j]) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  state_t w_nxt0 [NS];
  state_t w_nxt1 [NS];

  for (genvar gi = 0; gi < NS; gi++) begin : g_tbl
    if (gi < N) begin : g_live
      assign w_nxt0[gi] = SW'(kmp_next(gi, 1'b0));
      assign w_nxt1[gi] = SW'(kmp_next(gi, 1'b1));
    end else begin : g_dead
      assign w_nxt0[gi] = '0;
      assign w_nxt1[gi] = '0;
    end
  end

  state_t           r_state;
  logic             r_y_q;
  logic [CNT_W-1:0] r_cnt;

  logic   w_match;
  state_t w_state_next;

  // Reset masks the match so that no bit is consumed while rst is high.
  assign w_match = !rst && x_valid && (r_state == LAST) && (x == PATTERN[0]);

  always_comb begin
    w_state_next = x ? w_nxt1[r_state] : w_nxt0[r_state];
    // Without overlap, a completed pattern always restarts from scratch.
    if (w_match && !OVERLAP) w_state_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_y_q   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_y_q <= w_match;
      if (x_valid) r_state <= w_state_next;
      // Clear takes priority over a coincident match.
      if (clr_cnt)                          r_cnt <= '0;
      else if (w_match && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign y         = w_match;
  assign y_q       = r_y_q;
  assign match_cnt = r_cnt;
  assign state     = r_state;

endmodule
